// File: rtl/pc_target_table.sv
// pc_target_table: runtime-loaded branch-index to PC-target table.
// Entries carry no reset; a scrub pass clears them one per cycle.
module pc_target_table #(
   parameter int unsigned   D           = 12,
   parameter int unsigned   AW          = 8,
   parameter int unsigned   DEPTH       = 64,
   parameter logic [D-1:0]  DEFAULT_TGT = '0,
   localparam int unsigned  CW          = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rd_addr,
   output logic [D-1:0]  target,
   output logic          hit,
   input  logic          wr_en,
   input  logic          wr_inv,
   input  logic [AW-1:0] wr_addr,
   input  logic [D-1:0]  wr_data,
   output logic          wr_ack,
   input  logic          clr_req,
   output logic          busy,
   output logic [CW-1:0] n_valid
);

   localparam int unsigned   IW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_A = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] nv_q, nv_d;
   logic          ack_q, ack_d;

   logic [D-1:0]  mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q;

   logic [IW-1:0] widx, ridx;
   logic          w_rng, r_rng, w_acc, w_go, cur_vld;

   assign widx    = wr_addr[IW-1:0];
   assign ridx    = rd_addr[IW-1:0];
   assign w_rng   = {1'b0, wr_addr} < DEPTH_A;
   assign r_rng   = {1'b0, rd_addr} < DEPTH_A;
   assign w_acc   = wr_en & (state_q == IDLE) & ~clr_req;
   assign w_go    = w_acc & w_rng;
   assign cur_vld = vld_q[widx];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      nv_d    = nv_q;
      ack_d   = 1'b0;
      unique case (state_q)
         CLEAR: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
               nv_d    = '0;
            end else if (wr_en) begin
               ack_d = 1'b1;
               if (w_rng) begin
                  if (!wr_inv && !cur_vld && nv_q < FULL)
                     nv_d = nv_q + 1'b1;
                  else if (wr_inv && cur_vld && nv_q != '0)
                     nv_d = nv_q - 1'b1;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         nv_q    <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         nv_q    <= nv_d;
         ack_q   <= ack_d;
      end
   end

   // Storage is RAM-like: cleared only by the scrub walk, never by reset.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem_q[ptr_q] <= DEFAULT_TGT;
         vld_q[ptr_q] <= 1'b0;
      end else if (w_go) begin
         vld_q[widx] <= ~wr_inv;
         if (!wr_inv)
            mem_q[widx] <= wr_data;
      end
   end

   assign busy    = (state_q == CLEAR);
   assign hit     = r_rng & vld_q[ridx] & ~busy;
   assign target  = hit ? mem_q[ridx] : DEFAULT_TGT;
   assign wr_ack  = ack_q;
   assign n_valid = nv_q;

endmodule

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
- Runtime-programmable branch-target table for the custom CPU fetch stage.
- Maps a branch index to a D-bit PC target, with a per-entry valid bit, a hit flag and an occupancy count.
- Storage is RAM-like with no bulk reset. After reset, or on request, a scrub state machine clears entries one per cycle.
- Loaded by the host or test harness through a single write port.

Parameters:
- D, 12, target (PC) width in bits
- AW, 8, index width of rd_addr/wr_addr
- DEPTH, 64, number of entries; legal range 2..2**AW
- DEFAULT_TGT, 0, target driven on miss, invalid entry, or while busy
- CW, $clog2(DEPTH+1), width of n_valid (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- rd_addr  input  AW  branch index to look up
- target  output  D  looked-up target (combinational from rd_addr and stored state)
- hit  output  1  1 when rd_addr < DEPTH, the entry is valid, and the block is not busy
- wr_en  input  1  write/invalidate request, sampled on clk
- wr_inv  input  1  with wr_en: 1 = invalidate entry, 0 = write wr_data and set valid
- wr_addr  input  AW  entry to write or invalidate
- wr_data  input  D  target value to store
- wr_ack  output  1  one-cycle pulse the cycle after a write or invalidate is accepted
- clr_req  input  1  request a full scrub, sampled on clk
- busy  output  1  1 while a scrub is in progress
- n_valid  output  CW  count of valid entries

Behaviour:
- State: array of DEPTH entries {valid, data[D-1:0]} with no reset; FSM {IDLE, CLEAR}; scrub pointer ptr; counter n_valid; wr_ack register.
- Reset (async, immediate): FSM=CLEAR, ptr=0, n_valid=0, wr_ack=0. Therefore busy=1, hit=0, target=DEFAULT_TGT.
- CLEAR:
  - Each rising edge writes {0, DEFAULT_TGT} to entry ptr, then ptr++.
  - On the edge where ptr==DEPTH-1: FSM to IDLE, ptr to 0.
  - Scrub takes exactly DEPTH edges; busy falls after the DEPTH-th edge following reset release.
- While busy:
  - wr_en is ignored; no array change, no wr_ack.
  - clr_req is ignored; the scrub does not restart.
  - Reads return hit=0, target=DEFAULT_TGT.
- IDLE, clr_req=1: next edge enters CLEAR with ptr=0 and n_valid=0. clr_req wins over a simultaneous wr_en; that write is dropped with no ack.
- Write acceptance: wr_en=1, FSM=IDLE, clr_req=0. wr_ack=1 in the following cycle only, otherwise 0. Back-to-back writes are accepted every cycle.
- Out-of-range write (wr_addr >= DEPTH): accepted and acked, but the array and n_valid are unchanged.
- Write, wr_inv=0: entry <= {1, wr_data}. n_valid+1 if the entry was invalid, else unchanged (overwrite).
- Invalidate, wr_inv=1: valid <= 0, data unchanged. n_valid-1 if the entry was valid, else unchanged.
- n_valid never exceeds DEPTH and never wraps below 0.
- Read path is fully combinational, with no bypass. A write to the rd_addr entry becomes visible only after the accepting edge; in the same cycle the old value is shown.
- Read, rd_addr >= DEPTH or entry invalid: hit=0, target=DEFAULT_TGT.
- Read, valid entry: hit=1, target=stored data.
- Reset asserted mid-scrub or mid-write: the scrub restarts from ptr=0, any pending wr_ack is cleared, and the in-flight write is lost.

Test Plan:
- Assert reset, release, hold clr_req=0 -> busy=1 for exactly 64 cycles then 0. rd_addr=0..63 all give hit=0, target=0x000. n_valid=0.
- After scrub: write addr 5 data 0x123 -> wr_ack=1 the next cycle only. rd_addr=5 gives hit=1, target=0x123, n_valid=1. Same-cycle read before the edge gives hit=0.
- Overwrite addr 5 with 0xABC, then invalidate addr 5, then invalidate addr 5 again -> n_valid goes 1, 1, 0, 0. Final read gives hit=0, target=0x000.
- Write addr 70 (out of range) data 0x055 -> wr_ack=1, n_valid unchanged. rd_addr=70 gives hit=0, target=0x000.
- Fill addrs 0..63, then apply clr_req together with wr_en (addr 1) -> no wr_ack, n_valid=0 next cycle, busy for 64 cycles. Writes issued during busy get no ack. All entries read hit=0 afterwards.
- Assert reset at scrub ptr=30 -> busy stays 1 and the scrub takes a full 64 cycles from release. Reset during an ack cycle forces wr_ack=0 immediately.
